// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT core.
// Contents:
//   state_e          - core FSM state (load samples, compute butterflies, stream bins)
//   clog2            - ceiling log2 for elaboration-time sizing
//   bitrev           - reverse the low 'bits' bits of a value (DIT input ordering)
//   tw_re / tw_im    - twiddle W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), signed Q2.(TW-2),
//                      rounded to nearest; evaluated at elaboration only
package fft_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StCompute,
        StUnload
    } state_e;

    localparam real Pi = 3.14159265358979323846;

    function automatic int clog2(input int unsigned value);
        int r = 0;
        while ((32'd1 << r) < value) r++;
        return r;
    endfunction

    function automatic int unsigned bitrev(input int unsigned value, input int unsigned bits);
        int unsigned r = 0;
        for (int unsigned i = 0; i < bits; i++) begin
            r = (r << 1) | ((value >> i) & 32'd1);
        end
        return r;
    endfunction

    function automatic int tw_re(input int k, input int n, input int tw);
        real ang;
        ang = 2.0 * Pi * real'(k) / real'(n);
        return int'($cos(ang) * (2.0 ** (tw - 2)));
    endfunction

    function automatic int tw_im(input int k, input int n, input int tw);
        real ang;
        ang = 2.0 * Pi * real'(k) / real'(n);
        return int'(-$sin(ang) * (2.0 ** (tw - 2)));
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: top = a + b*w, bot = a - b*w.
// Ports:
//   i_a_re/i_a_im  - upper input (OW bits, signed)
//   i_b_re/i_b_im  - lower input (OW bits, signed)
//   i_w_re/i_w_im  - twiddle, signed Q2.(TW-2)
//   o_top_*/o_bot_* - butterfly outputs (OW bits, signed)
// The product b*w is kept at full precision, rounded half-up at the Q2.(TW-2) point
// and truncated to OW bits; the caller sizes OW so no result can overflow.
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int OW = 20,
    parameter int TW = 18
) (
    input  logic signed [OW-1:0] i_a_re,
    input  logic signed [OW-1:0] i_a_im,
    input  logic signed [OW-1:0] i_b_re,
    input  logic signed [OW-1:0] i_b_im,
    input  logic signed [TW-1:0] i_w_re,
    input  logic signed [TW-1:0] i_w_im,
    output logic signed [OW-1:0] o_top_re,
    output logic signed [OW-1:0] o_top_im,
    output logic signed [OW-1:0] o_bot_re,
    output logic signed [OW-1:0] o_bot_im
);

    localparam int PW = OW + TW + 1;
    localparam logic signed [PW-1:0] Half = PW'(1) <<< (TW - 3);

    logic signed [PW-1:0] w_bre, w_bim, w_wre, w_wim;
    logic signed [PW-1:0] w_pr, w_pi;
    logic signed [OW-1:0] w_t_re, w_t_im;

    assign w_bre = PW'(i_b_re);
    assign w_bim = PW'(i_b_im);
    assign w_wre = PW'(i_w_re);
    assign w_wim = PW'(i_w_im);

    assign w_pr = w_bre * w_wre - w_bim * w_wim;
    assign w_pi = w_bre * w_wim + w_bim * w_wre;

    assign w_t_re = OW'((w_pr + Half) >>> (TW - 2));
    assign w_t_im = OW'((w_pi + Half) >>> (TW - 2));

    assign o_top_re = i_a_re + w_t_re;
    assign o_top_im = i_a_im + w_t_im;
    assign o_bot_re = i_a_re - w_t_re;
    assign o_bot_im = i_a_im - w_t_im;

endmodule

// File: rtl/fft_stream_core.sv
// Sequential in-place radix-2 DIT FFT with valid/ready sample input and bin output.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - real sample stream (in_data, W bits signed); ready only in LOAD
//   out_valid/out_ready - complex bin stream in natural order (out_re/out_im, OW bits)
//   out_idx, out_last   - bin index and end-of-frame marker
//   busy                - high while computing or unloading
// Samples are stored bit-reversed so one butterfly per cycle walks the stages in place;
// the UNLOAD phase then reads the buffer in natural order.
module fft_stream_core
    import fft_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 16,
    parameter int TW = 18,
    localparam int LOG2N = clog2(N),
    localparam int OW = W + LOG2N + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic [LOG2N-1:0]     out_idx,
    output logic                 out_last,
    output logic                 busy
);

    state_e                r_state;
    logic [LOG2N-1:0]      r_cnt;    // sample count in LOAD, bin index in UNLOAD
    logic [LOG2N-1:0]      r_stage;
    logic [LOG2N-2:0]      r_bfly;
    logic signed [OW-1:0]  r_re [N];
    logic signed [OW-1:0]  r_im [N];

    logic signed [TW-1:0]  w_tw_re [N/2];
    logic signed [TW-1:0]  w_tw_im [N/2];
    logic [LOG2N-1:0]      w_ld_addr, w_top, w_bot;
    logic [LOG2N-2:0]      w_twi;
    logic signed [OW-1:0]  w_top_re, w_top_im, w_bot_re, w_bot_im;

    for (genvar g = 0; g < N / 2; g++) begin : g_tw
        assign w_tw_re[g] = TW'(tw_re(g, N, TW));
        assign w_tw_im[g] = TW'(tw_im(g, N, TW));
    end

    assign w_ld_addr = LOG2N'(bitrev(32'(r_cnt), LOG2N));

    // Butterfly addressing: span h = 2^s, top = (j>>s)*2h + (j mod h), bot = top + h.
    always_comb begin
        int unsigned v_j, v_s, v_h, v_top;
        v_j   = 32'(r_bfly);
        v_s   = 32'(r_stage);
        v_h   = 32'd1 << v_s;
        v_top = ((v_j >> v_s) << (v_s + 1)) | (v_j & (v_h - 1));
        w_top = LOG2N'(v_top);
        w_bot = LOG2N'(v_top + v_h);
        w_twi = (LOG2N - 1)'((v_j & (v_h - 1)) << (LOG2N - 1 - v_s));
    end

    fft_butterfly #(
        .OW(OW),
        .TW(TW)
    ) u_bfly (
        .i_a_re  (r_re[w_top]),
        .i_a_im  (r_im[w_top]),
        .i_b_re  (r_re[w_bot]),
        .i_b_im  (r_im[w_bot]),
        .i_w_re  (w_tw_re[w_twi]),
        .i_w_im  (w_tw_im[w_twi]),
        .o_top_re(w_top_re),
        .o_top_im(w_top_im),
        .o_bot_re(w_bot_re),
        .o_bot_im(w_bot_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StLoad;
            r_cnt   <= '0;
            r_stage <= '0;
            r_bfly  <= '0;
        end else begin
            unique case (r_state)
                StLoad: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LOG2N'(N - 1)) r_state <= StCompute;
                    end
                end
                StCompute: begin
                    r_bfly <= r_bfly + 1'b1;
                    if (&r_bfly) begin
                        if (r_stage == LOG2N'(LOG2N - 1)) begin
                            r_stage <= '0;
                            r_state <= StUnload;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                        end
                    end
                end
                StUnload: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (&r_cnt) r_state <= StLoad;
                    end
                end
                default: r_state <= StLoad;
            endcase
        end
    end

    // Sample/working buffer; contents are don't-care after reset, so it has none.
    always_ff @(posedge clk) begin
        if (r_state == StLoad && in_valid) begin
            r_re[w_ld_addr] <= OW'(in_data);
            r_im[w_ld_addr] <= '0;
        end else if (r_state == StCompute) begin
            r_re[w_top] <= w_top_re;
            r_im[w_top] <= w_top_im;
            r_re[w_bot] <= w_bot_re;
            r_im[w_bot] <= w_bot_im;
        end
    end

    assign in_ready  = (r_state == StLoad);
    assign busy      = (r_state != StLoad);
    assign out_valid = (r_state == StUnload);
    assign out_idx   = out_valid ? r_cnt : '0;
    assign out_last  = out_valid && (&r_cnt);
    // Gated so the bin outputs read 0 outside UNLOAD regardless of buffer contents.
    assign out_re    = out_valid ? r_re[r_cnt] : '0;
    assign out_im    = out_valid ? r_im[r_cnt] : '0;

endmodule

// File: tb/tb_fft_stream_core.sv
// Scoreboard bench for fft_stream_core: N=8 (impulse, reference frame, backpressure,
// reset mid-compute, latency), N=16 (DC at full negative scale), N=64 (random frames).
module tb_fft_stream_core;

    typedef struct {
        int  idx;
        real re;
        real im;
        real tol;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;
    longint last_accept_cyc = 0;
    bit     rnd_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // N=8 instance
    logic               a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic               a_in_ready, a_out_valid, a_out_last, a_busy;
    logic signed [15:0] a_in_data = '0;
    logic signed [19:0] a_out_re, a_out_im;
    logic [2:0]         a_out_idx;
    // N=16 instance
    logic               b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic               b_in_ready, b_out_valid, b_out_last, b_busy;
    logic signed [15:0] b_in_data = '0;
    logic signed [20:0] b_out_re, b_out_im;
    logic [3:0]         b_out_idx;
    // N=64 instance
    logic               c_in_valid = 1'b0, c_out_ready = 1'b0;
    logic               c_in_ready, c_out_valid, c_out_last, c_busy;
    logic signed [15:0] c_in_data = '0;
    logic signed [22:0] c_out_re, c_out_im;
    logic [5:0]         c_out_idx;

    exp_t sb_a[$], sb_b[$], sb_c[$];
    exp_t ea, eb, ec;
    bit   ha, hb, hc;

    fft_stream_core #(.N(8), .W(16), .TW(18)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_re(a_out_re), .out_im(a_out_im), .out_idx(a_out_idx),
        .out_last(a_out_last), .busy(a_busy)
    );
    fft_stream_core #(.N(16), .W(16), .TW(18)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_re(b_out_re), .out_im(b_out_im), .out_idx(b_out_idx),
        .out_last(b_out_last), .busy(b_busy)
    );
    fft_stream_core #(.N(64), .W(16), .TW(18)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_re(c_out_re), .out_im(c_out_im), .out_idx(c_out_idx),
        .out_last(c_out_last), .busy(c_busy)
    );

    task automatic check(input string name, input real got, input real expv, input real tol);
        n_vec++;
        if ((got - expv > tol) || (expv - got > tol)) begin
            n_err++;
            $display("FAIL %s: got %0.3f, expected %0.3f (tol %0.3f)", name, got, expv, tol);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired, got timeout, expected DUT event", name);
    endtask

    task automatic check_bin(input string tag, input bit have, input exp_t e, input int idx,
                             input real re, input real im, input bit last, input int n);
        if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL %s unexpected bin: got idx %0d, expected no output", tag, idx);
            return;
        end
        check($sformatf("%s idx", tag), real'(idx), real'(e.idx), 0.0);
        check($sformatf("%s X%0d re", tag, e.idx), re, e.re, e.tol);
        check($sformatf("%s X%0d im", tag, e.idx), im, e.im, e.tol);
        check($sformatf("%s X%0d last", tag, e.idx), real'(last), (e.idx == n - 1) ? 1.0 : 0.0,
              0.0);
    endtask

    // Monitors: a handshake seen at the negedge completes at the following posedge.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            ha = (sb_a.size() != 0);
            if (ha) ea = sb_a.pop_front();
            check_bin("N8", ha, ea, int'(a_out_idx), real'(a_out_re), real'(a_out_im),
                      a_out_last, 8);
        end
        if (!rst && b_out_valid && b_out_ready) begin
            hb = (sb_b.size() != 0);
            if (hb) eb = sb_b.pop_front();
            check_bin("N16", hb, eb, int'(b_out_idx), real'(b_out_re), real'(b_out_im),
                      b_out_last, 16);
        end
        if (!rst && c_out_valid && c_out_ready) begin
            hc = (sb_c.size() != 0);
            if (hc) ec = sb_c.pop_front();
            check_bin("N64", hc, ec, int'(c_out_idx), real'(c_out_re), real'(c_out_im),
                      c_out_last, 64);
        end
    end

    // Random downstream stalls for the N=64 instance.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) c_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic bit ready_of(input int which);
        case (which)
            0:       return a_in_ready;
            1:       return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    function automatic int sb_size(input int which);
        case (which)
            0:       return sb_a.size();
            1:       return sb_b.size();
            default: return sb_c.size();
        endcase
    endfunction

    task automatic push(input int which, input int k, input real re, input real im,
                        input real tol);
        exp_t e;
        e.idx = k;
        e.re  = re;
        e.im  = im;
        e.tol = tol;
        case (which)
            0:       sb_a.push_back(e);
            1:       sb_b.push_back(e);
            default: sb_c.push_back(e);
        endcase
    endtask

    // Present one sample and hold it until accepted; returns just after the accept edge.
    task automatic send(input int which, input int v);
        int t = 0;
        case (which)
            0:       begin a_in_valid = 1'b1; a_in_data = 16'(v); end
            1:       begin b_in_valid = 1'b1; b_in_data = 16'(v); end
            default: begin c_in_valid = 1'b1; c_in_data = 16'(v); end
        endcase
        @(negedge clk);
        while (!ready_of(which) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_now("send");
        last_accept_cyc = cyc + 1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
    endtask

    task automatic drain(input int which);
        int t = 0;
        while ((sb_size(which) != 0 || !ready_of(which)) && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 20000) fail_now($sformatf("drain %0d", which));
    endtask

    int  ref_in [8] = '{120, 130, 0, 110, 0, 150, 200, 0};
    int  x [64];
    real ct [64], st [64];

    initial begin
        int  t;
        real re, im;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst in_ready", real'(a_in_ready), 1.0, 0.0);
        check("rst out_valid", real'(a_out_valid), 0.0, 0.0);
        check("rst out_last", real'(a_out_last), 0.0, 0.0);
        check("rst busy", real'(a_busy), 0.0, 0.0);
        check("rst out_idx", real'(a_out_idx), 0.0, 0.0);
        check("rst out_re", real'(a_out_re), 0.0, 0.0);
        check("rst out_im", real'(a_out_im), 0.0, 0.0);
        check("rst busy N16", real'(b_busy), 0.0, 0.0);
        check("rst busy N64", real'(c_busy), 0.0, 0.0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Impulse, N=8
        a_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) push(0, k, 1.0, 0.0, 0.0);
        for (int i = 0; i < 8; i++) send(0, (i == 0) ? 1 : 0);
        drain(0);

        // Reference frame with a 5-cycle stall on bin 3
        a_out_ready = 1'b0;
        push(0, 0, 710.0, 0.0, 0.0);
        push(0, 1, 28.0761, 136.3604, 1.0);
        push(0, 2, -80.0, -170.0, 0.0);
        push(0, 3, 211.9239, -263.6396, 1.0);
        push(0, 4, -70.0, 0.0, 0.0);
        push(0, 5, 211.9239, 263.6396, 1.0);
        push(0, 6, -80.0, 170.0, 0.0);
        push(0, 7, 28.0761, -136.3604, 1.0);
        for (int i = 0; i < 8; i++) send(0, ref_in[i]);
        t = 0;
        while (!a_out_valid && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) fail_now("ref out_valid");
        t = 0;
        while (a_out_idx != 3'd3 && t < 50) begin
            a_out_ready = 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        a_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall out_valid", real'(a_out_valid), 1.0, 0.0);
            check("stall out_idx", real'(a_out_idx), 3.0, 0.0);
            check("stall X3 re", real'(a_out_re), 211.9239, 1.0);
            check("stall X3 im", real'(a_out_im), -263.6396, 1.0);
        end
        a_out_ready = 1'b1;
        t = 0;
        while (!(a_out_valid && a_out_last) && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) fail_now("ref out_last");
        @(posedge clk);
        #1;
        check("in_ready after last", real'(a_in_ready), 1.0, 0.0);
        check("out_valid after last", real'(a_out_valid), 0.0, 0.0);

        // Reset during COMPUTE, then a fresh impulse frame
        for (int i = 0; i < 8; i++) send(0, 1000 * i - 3000);
        repeat (3) begin @(posedge clk); #1; end
        check("mid busy", real'(a_busy), 1.0, 0.0);
        rst = 1'b1;
        #1;
        check("mid rst in_ready", real'(a_in_ready), 1.0, 0.0);
        check("mid rst busy", real'(a_busy), 0.0, 0.0);
        check("mid rst out_valid", real'(a_out_valid), 0.0, 0.0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) push(0, k, 1.0, 0.0, 0.0);
        for (int i = 0; i < 8; i++) send(0, (i == 0) ? 1 : 0);
        check("in_ready after Nth accept", real'(a_in_ready), 0.0, 0.0);
        t = 0;
        while (!a_out_valid && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) fail_now("latency out_valid");
        // Clock edges from the final accept edge to the edge that raises out_valid.
        check("latency", real'(cyc - last_accept_cyc), 12.0, 0.0);
        drain(0);

        // DC at full negative scale, N=16
        b_out_ready = 1'b1;
        push(1, 0, -524288.0, 0.0, 0.0);
        for (int k = 1; k < 16; k++) push(1, k, 0.0, 0.0, 0.0);
        for (int i = 0; i < 16; i++) send(1, -32768);
        drain(1);

        // Random frames, N=64, random input gaps and output stalls
        for (int i = 0; i < 64; i++) begin
            ct[i] = $cos(2.0 * 3.14159265358979323846 * real'(i) / 64.0);
            st[i] = $sin(2.0 * 3.14159265358979323846 * real'(i) / 64.0);
        end
        rnd_en = 1'b1;
        for (int f = 0; f < 100; f++) begin
            for (int n = 0; n < 64; n++) x[n] = int'($urandom_range(0, 16384)) - 8192;
            for (int k = 0; k < 64; k++) begin
                re = 0.0;
                im = 0.0;
                for (int n = 0; n < 64; n++) begin
                    re += real'(x[n]) * ct[(k * n) % 64];
                    im -= real'(x[n]) * st[(k * n) % 64];
                end
                push(2, k, re, im, 6.0);
            end
            for (int n = 0; n < 64; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
                send(2, x[n]);
            end
        end
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no summary, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
